htp_tape_tx: RTL and testbench

Cassette tape transmitter for the Homelab core: serialises a byte stream into the Homelab pulse-coded tape waveform on a single bit. It is the transmit end of the tape path whose receive end is the ADC tape decoder feeding `CASS_IN`. It sits between a byte source and either the cassette audio output or a loop-back to `CASS_IN`. The byte source is the HTP player or a save buffer.

---
 rtl/htp_tape_tx_if.sv | 30 +++
 rtl/htp_tape_tx.sv | 188 ++++++++++++++++++
 tb/tb_htp_tape_tx.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/htp_tape_tx_if.sv
// ============================================================================
// Module     : htp_tape_tx_if
// Description: Byte-stream, control and status bundle for the tape transmitter
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

interface htp_tape_tx_if;
  logic       START;
  logic [7:0] DIN;
  logic       DIN_VALID;
  logic       DIN_LAST;
  logic       DIN_READY;
  logic       TAPE_OUT;
  logic       BUSY;
  logic       DONE;
  logic       UNDERRUN;

  modport master (
    output START, DIN, DIN_VALID, DIN_LAST,
    input  DIN_READY, TAPE_OUT, BUSY, DONE, UNDERRUN
  );

  modport slave (
    input  START, DIN, DIN_VALID, DIN_LAST,
    output DIN_READY, TAPE_OUT, BUSY, DONE, UNDERRUN
  );
endinterface

`default_nettype wire

// File: rtl/htp_tape_tx.sv
// ============================================================================
// Module     : htp_tape_tx
// Description: Homelab cassette transmitter (leader, sync, payload, trailer).
//              Define HTP_TAPE_TX_CHECKSUM_EN to append a mod-256 checksum byte.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module htp_tape_tx #(
  parameter int         CELL_CYCLES  = 4800,
  parameter int         PULSE_CYCLES = 600,
  parameter int         LEADER_BYTES = 256,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  wire logic     CLK,
  input  wire logic     RESET_N,
  htp_tape_tx_if.slave  bus
);

  localparam int CW = $clog2(CELL_CYCLES);
  localparam int LW = $clog2(LEADER_BYTES + 1);

  localparam logic [CW-1:0] c_cell_last = CW'(CELL_CYCLES - 1);
  localparam logic [CW-1:0] c_pulse     = CW'(PULSE_CYCLES);
  localparam logic [CW-1:0] c_half      = CW'(CELL_CYCLES / 2);
  localparam logic [CW-1:0] c_half_end  = CW'(CELL_CYCLES / 2 + PULSE_CYCLES);
  localparam logic [LW-1:0] c_leader    = LW'(LEADER_BYTES);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_leader = 3'd1;
  localparam logic [2:0] c_st_sync   = 3'd2;
  localparam logic [2:0] c_st_data   = 3'd3;
  localparam logic [2:0] c_st_trail  = 3'd4;
`ifdef HTP_TAPE_TX_CHECKSUM_EN
  localparam logic [2:0] c_st_csum   = 3'd5;
`endif

  logic [2:0]    r_state, w_state;
  logic [CW-1:0] r_cyc,   w_cyc;
  logic [2:0]    r_bit,   w_bit;
  logic [LW-1:0] r_cnt,   w_cnt;
  logic [7:0]    r_sh,    w_sh;
  logic          r_last,  w_last;
  logic          r_stall, w_stall;
  logic          r_tape,  w_tape;
  logic          r_done,  w_done;
  logic          r_under, w_under;
  logic          w_end_byte;
  logic          w_ready;
`ifdef HTP_TAPE_TX_CHECKSUM_EN
  logic [7:0]    r_csum,  w_csum;
`endif

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state <= c_st_idle;
      r_cyc   <= '0;
      r_bit   <= '0;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_last  <= 1'b0;
      r_stall <= 1'b0;
      r_tape  <= 1'b0;
      r_done  <= 1'b0;
      r_under <= 1'b0;
`ifdef HTP_TAPE_TX_CHECKSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      r_state <= w_state;
      r_cyc   <= w_cyc;
      r_bit   <= w_bit;
      r_cnt   <= w_cnt;
      r_sh    <= w_sh;
      r_last  <= w_last;
      r_stall <= w_stall;
      r_tape  <= w_tape;
      r_done  <= w_done;
      r_under <= w_under;
`ifdef HTP_TAPE_TX_CHECKSUM_EN
      r_csum  <= w_csum;
`endif
    end
  end

  always_comb begin
    w_state = r_state;
    w_cyc   = r_cyc;
    w_bit   = r_bit;
    w_cnt   = r_cnt;
    w_sh    = r_sh;
    w_last  = r_last;
    w_stall = r_stall;
    w_done  = 1'b0;
    w_under = r_under;
`ifdef HTP_TAPE_TX_CHECKSUM_EN
    w_csum  = r_csum;
`endif
    if (r_state == c_st_idle) begin
      if (bus.START) begin
        w_state = c_st_leader;
        w_cnt   = c_leader;
        w_sh    = 8'h00;
        w_cyc   = '0;
        w_bit   = '0;
        w_last  = 1'b0;
        w_stall = 1'b0;
        w_under = 1'b0;
`ifdef HTP_TAPE_TX_CHECKSUM_EN
        w_csum  = 8'h00;
`endif
      end
    end else if (w_ready) begin
      // A fetch always restarts at cell offset 0, so a stall never leaves a partial cell.
      w_cyc = '0;
      w_bit = '0;
      if (bus.DIN_VALID) begin
        w_state = c_st_data;
        w_sh    = bus.DIN;
        w_last  = bus.DIN_LAST;
        w_stall = 1'b0;
`ifdef HTP_TAPE_TX_CHECKSUM_EN
        w_csum  = r_csum + bus.DIN;
`endif
      end else begin
        w_stall = 1'b1;
        w_under = 1'b1;
      end
    end else if (r_cyc != c_cell_last) begin
      w_cyc = r_cyc + 1'b1;
    end else begin
      w_cyc = '0;
      w_bit = r_bit + 3'd1;
      w_sh  = {r_sh[6:0], 1'b0};
      if (r_bit == 3'd7) begin
        case (r_state)
          c_st_leader: begin
            if (r_cnt == LW'(1)) begin
              w_sh    = SYNC_BYTE;
              w_state = c_st_sync;
            end else begin
              w_cnt = r_cnt - LW'(1);
              w_sh  = 8'h00;
            end
          end
          c_st_data: begin
`ifdef HTP_TAPE_TX_CHECKSUM_EN
            w_sh    = r_csum;
            w_state = c_st_csum;
`else
            w_sh    = 8'h00;
            w_state = c_st_trail;
`endif
          end
`ifdef HTP_TAPE_TX_CHECKSUM_EN
          c_st_csum: begin
            w_sh    = 8'h00;
            w_state = c_st_trail;
          end
`endif
          default: begin
            w_state = c_st_idle;
            w_done  = 1'b1;
          end
        endcase
      end
    end
    // Waveform is registered, so it is derived from the position of the coming cycle.
    w_tape = (w_state != c_st_idle) && !w_stall &&
             ((w_cyc < c_pulse) ||
              (w_sh[7] && (w_cyc >= c_half) && (w_cyc < c_half_end)));
  end

  always_comb begin
    w_end_byte    = (r_cyc == c_cell_last) && (r_bit == 3'd7);
    w_ready       = r_stall ||
                    (w_end_byte && ((r_state == c_st_sync) ||
                                    ((r_state == c_st_data) && !r_last)));
    bus.DIN_READY = w_ready;
    bus.TAPE_OUT  = r_tape;
    bus.BUSY      = (r_state != c_st_idle);
    bus.DONE      = r_done;
    bus.UNDERRUN  = r_under;
  end

endmodule

`default_nettype wire

// File: tb/tb_htp_tape_tx.sv
// ============================================================================
// Module     : tb_htp_tape_tx
// Description: Randomised bench for htp_tape_tx against a per-cycle waveform model
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_htp_tape_tx;
  localparam int         CELL   = 16;
  localparam int         PULSE  = 2;
  localparam int         LEADER = 2;
  localparam logic [7:0] SYNC   = 8'hA5;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  htp_tape_tx_if bus ();

  htp_tape_tx #(
    .CELL_CYCLES (CELL),
    .PULSE_CYCLES(PULSE),
    .LEADER_BYTES(LEADER),
    .SYNC_BYTE   (SYNC)
  ) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .bus    (bus.slave)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_bad = 0;

  bit [7:0] pay[$];
  int       wt[$];
  bit       tape_q[$];
  bit       ur_q[$];
  bit       ur_end;

  bit drv_en = 0;
  int k = 0;
  int wcnt = 0;
  bit offered = 0;
  int hs_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference waveform: one entry per clock from the first busy cycle to the last.
  task automatic push_byte(input bit [7:0] v, input bit ur);
    for (int b = 7; b >= 0; b--)
      for (int t = 0; t < CELL; t++) begin
        tape_q.push_back((t < PULSE) || (v[b] && t >= CELL / 2 && t < CELL / 2 + PULSE));
        ur_q.push_back(ur);
      end
  endtask

  task automatic build_exp();
    bit [7:0] sum = 8'h00;
    bit ur = 1'b0;
    tape_q.delete();
    ur_q.delete();
    for (int i = 0; i < LEADER; i++) push_byte(8'h00, 1'b0);
    push_byte(SYNC, 1'b0);
    for (int p = 0; p < pay.size(); p++) begin
      if (wt[p] > 0) ur = 1'b1;
      for (int s = 0; s < wt[p]; s++) begin
        tape_q.push_back(1'b0);
        ur_q.push_back(ur);
      end
      push_byte(pay[p], ur);
      sum = sum + pay[p];
    end
`ifdef HTP_TAPE_TX_CHECKSUM_EN
    push_byte(sum, ur);
`endif
    push_byte(8'h00, ur);
    ur_end = ur;
  endtask

  always @(posedge CLK)
    if (RESET_N && bus.DIN_VALID && bus.DIN_READY) hs_seen++;

  // Byte source: withholds DIN_VALID for wt[k] fetch cycles, random noise otherwise.
  always @(negedge CLK) begin
    if (offered) begin
      k++;
      wcnt = 0;
    end
    offered = 1'b0;
    if (drv_en && bus.DIN_READY && k < pay.size()) begin
      if (wcnt < wt[k]) begin
        bus.DIN_VALID = 1'b0;
        bus.DIN       = 8'($urandom);
        wcnt++;
      end else begin
        bus.DIN_VALID = 1'b1;
        bus.DIN       = pay[k];
        bus.DIN_LAST  = (k == pay.size() - 1);
        offered       = 1'b1;
      end
    end else begin
      bus.DIN_VALID = 1'($urandom);
      bus.DIN       = 8'($urandom);
      bus.DIN_LAST  = 1'($urandom);
    end
  end

  task automatic arm_source();
    k = 0;
    wcnt = 0;
    offered = 1'b0;
    hs_seen = 0;
    drv_en = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_tape"},  bus.TAPE_OUT,  1'b0);
    check_eq({tag, "_busy"},  bus.BUSY,      1'b0);
    check_eq({tag, "_ready"}, bus.DIN_READY, 1'b0);
    check_eq({tag, "_done"},  bus.DONE,      1'b0);
    check_eq({tag, "_under"}, bus.UNDERRUN,  1'b0);
  endtask

  task automatic run_block(input bit hold);
    build_exp();
    arm_source();
    @(negedge CLK) bus.START = 1'b1;
    @(negedge CLK) if (!hold) bus.START = 1'b0;
    for (int i = 0; i < tape_q.size(); i++) begin
      check_eq("tape", bus.TAPE_OUT, tape_q[i]);
      check_eq("busy", bus.BUSY, 1'b1);
      check_eq("under", bus.UNDERRUN, ur_q[i]);
      check_eq("done_early", bus.DONE, 1'b0);
      @(negedge CLK);
    end
    check_eq("done", bus.DONE, 1'b1);
    check_eq("busy_end", bus.BUSY, 1'b0);
    check_eq("tape_end", bus.TAPE_OUT, 1'b0);
    check_eq("ready_end", bus.DIN_READY, 1'b0);
    check_eq("under_end", bus.UNDERRUN, ur_end);
    check_eq("handshakes", hs_seen, pay.size());
    drv_en = 1'b0;
  endtask

  task automatic rand_payload(input int n, input int first_wait);
    pay.delete();
    wt.delete();
    for (int i = 0; i < n; i++) begin
      pay.push_back(8'($urandom));
      wt.push_back(($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : 0);
    end
    if (first_wait >= 0) wt[0] = first_wait;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.START = 1'b0;
    bus.DIN = 8'h00;
    bus.DIN_VALID = 1'b0;
    bus.DIN_LAST = 1'b0;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (50) @(negedge CLK);
    check_idle("reset");

    pay = '{8'h3C};
    wt = '{0};
    run_block(1'b0);

    pay = '{8'h01, 8'hFF};
    wt = '{0, 0};
    run_block(1'b0);

    rand_payload(3, 37);
    run_block(1'b0);
    @(negedge CLK);
    check_eq("under_sticky", bus.UNDERRUN, 1'b1);
    repeat (5) @(negedge CLK);
    check_eq("under_sticky2", bus.UNDERRUN, 1'b1);

    for (int r = 0; r < 4; r++) begin
      rand_payload($urandom_range(1, 4), -1);
      run_block(1'b0);
      repeat ($urandom_range(0, 5)) @(negedge CLK);
    end

    begin
      int dn = 0;
      rand_payload(3, 0);
      arm_source();
      @(negedge CLK) bus.START = 1'b1;
      @(negedge CLK) bus.START = 1'b0;
      repeat ((LEADER + 1) * 8 * CELL + 20) @(negedge CLK);
      RESET_N = 1'b0;
      @(negedge CLK) RESET_N = 1'b1;
      drv_en = 1'b0;
      check_idle("midrst");
      repeat (8 * 8 * CELL) begin
        @(negedge CLK);
        if (bus.DONE) dn++;
      end
      check_eq("midrst_no_done", dn, 0);
    end

    rand_payload(2, 0);
    run_block(1'b0);

    pay = '{8'h5A, 8'hC3};
    wt = '{0, 0};
    run_block(1'b1);
    @(negedge CLK);
    check_eq("restart_busy", bus.BUSY, 1'b1);
    check_eq("restart_tape", bus.TAPE_OUT, 1'b1);
    bus.START = 1'b0;
    RESET_N = 1'b0;
    @(negedge CLK) RESET_N = 1'b1;
    @(negedge CLK);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
